// File: rtl/padring_pkg.sv
// Shared types and default widths for the padring test chip.
package padring_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_SYNC   = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_TMAP   = 2'd3
    } mode_t;

    localparam int unsigned DEF_N_IN  = 10;
    localparam int unsigned DEF_N_OUT = 10;

endpackage

// File: rtl/padring_sync2.sv
// Generic N-bit two-flop synchroniser with asynchronous active-low reset.
module padring_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/padring_test_core.sv
// Pad-test core: bypass/synchronised loopback, walking-one pattern and sticky
// toggle map between the input and output pad columns.
module padring_test_core
    import padring_pkg::*;
#(
    parameter int unsigned N_IN       = DEF_N_IN,
    parameter int unsigned N_OUT      = DEF_N_OUT,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    input  logic [N_IN-1:0]  ui_in,
    output logic [N_OUT-1:0] uo_out,
    output logic             tick_o
);

    localparam int unsigned N_MIN = (N_IN < N_OUT) ? N_IN : N_OUT;

    // Low bits pass through; missing inputs read as 0, surplus inputs are dropped.
    function automatic logic [N_OUT-1:0] map_in(input logic [N_IN-1:0] x);
        logic [N_OUT-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < N_MIN; i++) begin
            res[i] = x[i];
        end
        return res;
    endfunction

    logic [N_IN-1:0]       s2;
    logic [N_IN-1:0]       s3;
    logic [N_IN-1:0]       tmap;
    mode_t                 mode_q;
    logic                  mode_chg;
    logic [PRESCALE_W-1:0] cnt;
    logic                  tick;
    logic [N_OUT-1:0]      walk;
    logic [N_OUT-1:0]      walk_rot;

    padring_sync2 #(.W(N_IN)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in),
        .q     (s2)
    );

    // For N_OUT = 1 both shift terms collapse so the single bit stays set.
    assign walk_rot = (walk << 1) | (walk >> (N_OUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3       <= '0;
            mode_q   <= MODE_BYPASS;
            mode_chg <= 1'b0;
            cnt      <= '0;
            tick     <= 1'b0;
            walk     <= '0;
            tmap     <= '0;
        end else begin
            s3       <= s2;
            mode_q   <= mode_t'(mode_i);
            mode_chg <= (mode_t'(mode_i) != mode_q);
            if (mode_chg) begin
                // Mode entry restarts every pattern generator and the toggle map.
                cnt  <= '0;
                tick <= 1'b0;
                walk <= {{(N_OUT-1){1'b0}}, 1'b1};
                tmap <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= (cnt == '1);
                if (tick) begin
                    walk <= walk_rot;
                end
                tmap <= tmap | (s2 ^ s3);
            end
        end
    end

    always_comb begin
        uo_out = map_in(ui_in);
        case (mode_q)
            MODE_SYNC: uo_out = map_in(s2);
            MODE_WALK: uo_out = walk;
            MODE_TMAP: uo_out = map_in(tmap);
            default:   uo_out = map_in(ui_in);
        endcase
    end

    assign tick_o = tick;

endmodule
